// File: rtl/lsu_dport_axil_pkg.sv
// Shared types for the LSU data-port AXI4-Lite bridge: response codes,
// bridge states and request classification.
package lsu_dport_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_R,
        ST_CMO
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_WR,
        REQ_RD,
        REQ_CMO
    } req_kind_e;

    // Write beats read beats maintenance when several strobes are raised together.
    function automatic req_kind_e classify_req(input logic rd, input logic [3:0] wr,
                                               input logic cmo);
        if (|wr)     return REQ_WR;
        else if (rd) return REQ_RD;
        else if (cmo) return REQ_CMO;
        else         return REQ_NONE;
    endfunction

    // SLVERR and DECERR both have bit 1 set; EXOKAY counts as success.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/lsu_dport_axil.sv
// LSU memory request/ack port to AXI4-Lite master, one transaction in flight.
// Optional response timeout with orphan-response tracking: LSU_DPORT_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | accepting; captures request on any strobe
// WR      | AW and W outstanding, each drops on its own handshake
// WR_B    | waiting for write response
// RD_A    | AR outstanding
// RD_R    | waiting for read data
// CMO     | maintenance op, completes locally after one cycle
module lsu_dport_axil
    import lsu_dport_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic        mem_cacheable_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_invalidate_i,
    input  logic        mem_writeback_i,
    input  logic        mem_flush_i,
    output logic [31:0] mem_data_rd_o,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [10:0] mem_resp_tag_o,
    output logic        mem_load_fault_o,
    output logic        mem_store_fault_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_awaddr_o,
    output logic [2:0]  axi_awprot_o,
    output logic [3:0]  axi_awcache_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    input  logic [1:0]  axi_bresp_i,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    output logic [31:0] axi_araddr_o,
    output logic [2:0]  axi_arprot_o,
    output logic [3:0]  axi_arcache_o,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [10:0] tag_q, tag_d, resp_tag_q, resp_tag_d;
    logic        cache_q, cache_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        ack_q, ack_d, err_q, err_d;

    req_kind_e   kind;
    logic        b_take, r_take, tmo_hit, b_orph, r_orph, block_accept;
    logic [1:0]  unused_lsbs;

    assign kind = classify_req(mem_rd_i, mem_wr_i,
                               mem_invalidate_i | mem_writeback_i | mem_flush_i);
    assign unused_lsbs = mem_addr_i[1:0] ^ {axi_bresp_i[0], axi_rresp_i[0]};

    // A response only completes the live transaction once stale ones are drained.
    assign b_take = (state_q == ST_WR_B) && axi_bvalid_i && !b_orph;
    assign r_take = (state_q == ST_RD_R) && axi_rvalid_i && !r_orph;

`ifdef LSU_DPORT_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [1:0]           orph_b_q, orph_b_d, orph_r_q, orph_r_d;
    logic                 wait_st;

    assign wait_st      = (state_q == ST_WR_B) || (state_q == ST_RD_R);
    assign b_orph       = (orph_b_q != 2'd0);
    assign r_orph       = (orph_r_q != 2'd0);
    assign block_accept = (orph_b_q == 2'd3) || (orph_r_q == 2'd3);
    assign tmo_hit      = (tmo_q == '0) &&
                          (((state_q == ST_WR_B) && !b_take) || ((state_q == ST_RD_R) && !r_take));

    always_comb begin
        tmo_d    = (wait_st && !tmo_hit) ? tmo_q - 1'b1 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);
        orph_b_d = orph_b_q - {1'b0, axi_bvalid_i && b_orph};
        orph_r_d = orph_r_q - {1'b0, axi_rvalid_i && r_orph};
        if (tmo_hit && (state_q == ST_WR_B) && (orph_b_d != 2'd3)) orph_b_d = orph_b_d + 2'd1;
        if (tmo_hit && (state_q == ST_RD_R) && (orph_r_d != 2'd3)) orph_r_d = orph_r_d + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q    <= TIMEOUT_W'(TIMEOUT_CYCLES - 1);
            orph_b_q <= 2'd0;
            orph_r_q <= 2'd0;
        end else begin
            tmo_q    <= tmo_d;
            orph_b_q <= orph_b_d;
            orph_r_q <= orph_r_d;
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_tmo_cfg;

    assign unused_tmo_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign b_orph         = 1'b0;
    assign r_orph         = 1'b0;
    assign block_accept   = 1'b0;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            tag_q      <= '0;
            cache_q    <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            resp_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            tag_q      <= tag_d;
            cache_q    <= cache_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_tag_q <= resp_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        tag_d     = tag_q;
        cache_d   = cache_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_accept_o && (kind != REQ_NONE)) begin
                    addr_d    = {mem_addr_i[31:2], 2'b00};
                    data_d    = mem_data_wr_i;
                    strb_d    = mem_wr_i;
                    tag_d     = mem_req_tag_i;
                    cache_d   = mem_cacheable_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    case (kind)
                        REQ_WR:  state_d = ST_WR;
                        REQ_RD:  state_d = ST_RD_A;
                        default: state_d = ST_CMO;
                    endcase
                end
            end
            ST_WR: begin
                aw_done_d = aw_done_q | (axi_awvalid_o & axi_awready_i);
                w_done_d  = w_done_q  | (axi_wvalid_o  & axi_wready_i);
                if (aw_done_d && w_done_d) state_d = ST_WR_B;
            end
            ST_WR_B: if (b_take || tmo_hit) state_d = ST_IDLE;
            ST_RD_A: if (axi_arready_i) state_d = ST_RD_R;
            ST_RD_R: if (r_take || tmo_hit) state_d = ST_IDLE;
            ST_CMO:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        resp_tag_d = resp_tag_q;
        if (b_take || r_take || tmo_hit || (state_q == ST_CMO)) begin
            ack_d      = 1'b1;
            resp_tag_d = tag_q;
            rdata_d    = r_take ? axi_rdata_i : 32'h0;
            if (b_take)       err_d = resp_is_err(axi_bresp_i);
            else if (r_take)  err_d = resp_is_err(axi_rresp_i);
            else              err_d = tmo_hit;
        end
    end

    always_comb begin
        mem_accept_o  = (state_q == ST_IDLE) && !block_accept;
        axi_awvalid_o = (state_q == ST_WR) && !aw_done_q;
        axi_wvalid_o  = (state_q == ST_WR) && !w_done_q;
        axi_bready_o  = (state_q == ST_WR_B) || b_orph;
        axi_arvalid_o = (state_q == ST_RD_A);
        axi_rready_o  = (state_q == ST_RD_R) || r_orph;
    end

    assign axi_awaddr_o      = addr_q;
    assign axi_araddr_o      = addr_q;
    assign axi_awprot_o      = 3'b000;
    assign axi_arprot_o      = 3'b000;
    assign axi_awcache_o     = {2'b00, cache_q, 1'b0};
    assign axi_arcache_o     = {2'b00, cache_q, 1'b0};
    assign axi_wdata_o       = data_q;
    assign axi_wstrb_o       = strb_q;
    assign mem_data_rd_o     = rdata_q;
    assign mem_ack_o         = ack_q;
    assign mem_error_o       = err_q;
    assign mem_resp_tag_o    = resp_tag_q;
    assign mem_load_fault_o  = 1'b0;
    assign mem_store_fault_o = 1'b0;

endmodule

// File: tb/tb_lsu_dport_axil.sv
// Directed bench for lsu_dport_axil: reads, writes, errors, CMO, reset abort;
// timeout/orphan scenario when LSU_DPORT_TIMEOUT_EN is defined.
module tb_lsu_dport_axil;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr_i, mem_data_wr_i;
    logic        mem_rd_i;
    logic [3:0]  mem_wr_i;
    logic        mem_cacheable_i;
    logic [10:0] mem_req_tag_i;
    logic        mem_invalidate_i, mem_writeback_i, mem_flush_i;
    logic [31:0] mem_data_rd_o;
    logic        mem_accept_o, mem_ack_o, mem_error_o;
    logic [10:0] mem_resp_tag_o;
    logic        mem_load_fault_o, mem_store_fault_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [2:0]  axi_awprot_o;
    logic [3:0]  axi_awcache_o;
    logic        axi_wvalid_o, axi_wready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [2:0]  axi_arprot_o;
    logic [3:0]  axi_arcache_o;
    logic        axi_rvalid_i, axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_dport_axil #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i), .mem_rd_i(mem_rd_i),
        .mem_wr_i(mem_wr_i), .mem_cacheable_i(mem_cacheable_i), .mem_req_tag_i(mem_req_tag_i),
        .mem_invalidate_i(mem_invalidate_i), .mem_writeback_i(mem_writeback_i),
        .mem_flush_i(mem_flush_i), .mem_data_rd_o(mem_data_rd_o), .mem_accept_o(mem_accept_o),
        .mem_ack_o(mem_ack_o), .mem_error_o(mem_error_o), .mem_resp_tag_o(mem_resp_tag_o),
        .mem_load_fault_o(mem_load_fault_o), .mem_store_fault_o(mem_store_fault_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_awaddr_o(axi_awaddr_o), .axi_awprot_o(axi_awprot_o), .axi_awcache_o(axi_awcache_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_bresp_i(axi_bresp_i), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_araddr_o(axi_araddr_o), .axi_arprot_o(axi_arprot_o), .axi_arcache_o(axi_arcache_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
        .axi_rresp_i(axi_rresp_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        mem_rd_i = 1'b0; mem_wr_i = 4'h0; mem_invalidate_i = 1'b0;
        mem_writeback_i = 1'b0; mem_flush_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        mem_addr_i = '0; mem_data_wr_i = '0; mem_cacheable_i = 1'b0; mem_req_tag_i = '0;
        axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
        axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_accept", mem_accept_o, 1);
        check("rst_ack", mem_ack_o, 0);
        check("rst_err", mem_error_o, 0);
        check("rst_data", mem_data_rd_o, 0);
        check("rst_tag", mem_resp_tag_o, 0);
        check("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        check("rst_readies", {axi_bready_o, axi_rready_o}, 0);
        check("faults_tied", {mem_load_fault_o, mem_store_fault_o}, 0);
        #2 rst_n = 1'b1;
        tick();

        // Read, zero-wait slave
        mem_rd_i = 1'b1; mem_addr_i = 32'h8000_0010; mem_req_tag_i = 11'h055;
        check("rd_accept", mem_accept_o, 1);
        tick(); clear_req();
        check("rd_arvalid", axi_arvalid_o, 1);
        check("rd_araddr", axi_araddr_o, 32'h8000_0010);
        check("rd_arattr", {axi_arprot_o, axi_arcache_o}, 7'b000_0000);
        check("rd_accept_busy", mem_accept_o, 0);
        check("rd_no_aw", axi_awvalid_o, 0);
        axi_arready_i = 1'b1;
        tick(); axi_arready_i = 1'b0;
        check("rd_arvalid_drop", axi_arvalid_o, 0);
        check("rd_rready", axi_rready_o, 1);
        check("rd_no_early_ack", mem_ack_o, 0);
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hDEAD_BEEF; axi_rresp_i = 2'b00;
        tick(); axi_rvalid_i = 1'b0;
        check("rd_ack", mem_ack_o, 1);
        check("rd_data", mem_data_rd_o, 32'hDEAD_BEEF);
        check("rd_tag", mem_resp_tag_o, 11'h055);
        check("rd_err", mem_error_o, 0);
        check("rd_accept_again", mem_accept_o, 1);
        tick();
        check("rd_ack_pulse", mem_ack_o, 0);

        // Byte store, W handshake 3 cycles after AW
        mem_wr_i = 4'b1000; mem_addr_i = 32'h8000_0003; mem_data_wr_i = 32'hAA00_0000;
        mem_req_tag_i = 11'h123; mem_cacheable_i = 1'b1;
        tick(); clear_req(); mem_cacheable_i = 1'b0;
        check("wr_awvalid", axi_awvalid_o, 1);
        check("wr_wvalid", axi_wvalid_o, 1);
        check("wr_awaddr", axi_awaddr_o, 32'h8000_0000);
        check("wr_wstrb", axi_wstrb_o, 4'b1000);
        check("wr_wdata", axi_wdata_o, 32'hAA00_0000);
        check("wr_awcache", {axi_awprot_o, axi_awcache_o}, 7'b000_0010);
        axi_awready_i = 1'b1;
        tick(); axi_awready_i = 1'b0;
        check("wr_aw_drop", axi_awvalid_o, 0);
        for (int i = 0; i < 2; i++) begin
            check("wr_w_held", axi_wvalid_o, 1);
            tick();
        end
        check("wr_w_held", axi_wvalid_o, 1);
        axi_wready_i = 1'b1;
        tick(); axi_wready_i = 1'b0;
        check("wr_w_drop", axi_wvalid_o, 0);
        check("wr_bready", axi_bready_o, 1);
        tick();
        check("wr_wait_b", mem_ack_o, 0);
        axi_bvalid_i = 1'b1; axi_bresp_i = 2'b00;
        tick(); axi_bvalid_i = 1'b0;
        check("wr_ack", mem_ack_o, 1);
        check("wr_err", mem_error_o, 0);
        check("wr_data_zero", mem_data_rd_o, 0);
        check("wr_tag", mem_resp_tag_o, 11'h123);
        check("wr_bready_drop", axi_bready_o, 0);

        // Write with AW and W in the same cycle, DECERR response
        mem_wr_i = 4'hF; mem_addr_i = 32'h1000_0040; mem_data_wr_i = 32'h0102_0304;
        mem_req_tag_i = 11'h3A5;
        tick(); clear_req();
        axi_awready_i = 1'b1; axi_wready_i = 1'b1;
        tick(); axi_awready_i = 1'b0; axi_wready_i = 1'b0;
        check("wr2_valids_drop", {axi_awvalid_o, axi_wvalid_o}, 0);
        check("wr2_bready", axi_bready_o, 1);
        axi_bvalid_i = 1'b1; axi_bresp_i = 2'b11;
        tick(); axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
        check("wr2_ack", mem_ack_o, 1);
        check("wr2_decerr", mem_error_o, 1);
        check("wr2_tag", mem_resp_tag_o, 11'h3A5);

        // Read with SLVERR, then back-to-back read ending in EXOKAY
        mem_rd_i = 1'b1; mem_addr_i = 32'h2000_0000; mem_req_tag_i = 11'h011;
        tick(); clear_req();
        axi_arready_i = 1'b1;
        tick(); axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'h5555_AAAA; axi_rresp_i = 2'b10;
        tick(); axi_rvalid_i = 1'b0; axi_rresp_i = 2'b00;
        check("slverr_ack", mem_ack_o, 1);
        check("slverr_err", mem_error_o, 1);
        check("slverr_tag", mem_resp_tag_o, 11'h011);
        check("b2b_accept", mem_accept_o, 1);
        mem_rd_i = 1'b1; mem_addr_i = 32'h2000_0004; mem_req_tag_i = 11'h012;
        tick(); clear_req();
        check("b2b_arvalid", axi_arvalid_o, 1);
        check("b2b_araddr", axi_araddr_o, 32'h2000_0004);
        axi_arready_i = 1'b1;
        tick(); axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'h0BAD_F00D; axi_rresp_i = 2'b01;
        tick(); axi_rvalid_i = 1'b0; axi_rresp_i = 2'b00;
        check("exokay_ack", mem_ack_o, 1);
        check("exokay_err", mem_error_o, 0);
        check("exokay_data", mem_data_rd_o, 32'h0BAD_F00D);

        // Flush: local completion
        mem_flush_i = 1'b1; mem_req_tag_i = 11'h200;
        check("cmo_accept", mem_accept_o, 1);
        tick(); clear_req();
        check("cmo_accept_low", mem_accept_o, 0);
        check("cmo_no_axi", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        check("cmo_no_ack_yet", mem_ack_o, 0);
        tick();
        check("cmo_ack", mem_ack_o, 1);
        check("cmo_err", mem_error_o, 0);
        check("cmo_data", mem_data_rd_o, 0);
        check("cmo_tag", mem_resp_tag_o, 11'h200);
        check("cmo_accept_back", mem_accept_o, 1);
        tick();

        // W before AW, then reset while in WR_B
        mem_wr_i = 4'hF; mem_addr_i = 32'h8000_0100; mem_data_wr_i = 32'h1234_5678;
        mem_req_tag_i = 11'h7FF;
        tick(); clear_req();
        axi_wready_i = 1'b1;
        tick(); axi_wready_i = 1'b0;
        check("wfirst_w_drop", axi_wvalid_o, 0);
        check("wfirst_aw_held", axi_awvalid_o, 1);
        axi_awready_i = 1'b1;
        tick(); axi_awready_i = 1'b0;
        check("wfirst_bready", axi_bready_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        check("rstmid_readies", {axi_bready_o, axi_rready_o}, 0);
        check("rstmid_accept", mem_accept_o, 1);
        tick();
        axi_bvalid_i = 1'b1;
        rst_n = 1'b1;
        tick(); axi_bvalid_i = 1'b0;
        check("rstmid_no_ack", mem_ack_o, 0);
        check("rstmid_bready", axi_bready_o, 0);
        tick();
        check("rstmid_no_ack2", mem_ack_o, 0);
        check("rstmid_accept2", mem_accept_o, 1);

`ifdef LSU_DPORT_TIMEOUT_EN
        // Read whose data never arrives; late response later swallowed
        mem_rd_i = 1'b1; mem_addr_i = 32'h3000_0000; mem_req_tag_i = 11'h0AB;
        tick(); clear_req();
        axi_arready_i = 1'b1;
        tick(); axi_arready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_wait", mem_ack_o, 0);
        end
        tick();
        check("tmo_ack", mem_ack_o, 1);
        check("tmo_err", mem_error_o, 1);
        check("tmo_tag", mem_resp_tag_o, 11'h0AB);
        check("tmo_orphan_rready", axi_rready_o, 1);
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hFFFF_0000;
        tick(); axi_rvalid_i = 1'b0;
        check("tmo_late_swallowed", mem_ack_o, 0);
        check("tmo_rready_idle", axi_rready_o, 0);
        mem_rd_i = 1'b1; mem_addr_i = 32'h3000_0008; mem_req_tag_i = 11'h0AC;
        tick(); clear_req();
        axi_arready_i = 1'b1;
        tick(); axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hCAFE_0001;
        tick(); axi_rvalid_i = 1'b0;
        check("tmo_next_ack", mem_ack_o, 1);
        check("tmo_next_data", mem_data_rd_o, 32'hCAFE_0001);
        check("tmo_next_err", mem_error_o, 0);
        check("tmo_next_tag", mem_resp_tag_o, 11'h0AC);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
